elapsed_display_driver: RTL and testbench
=========================================

ELAPSED_DISPLAY_DRIVER -- requirements
Module: elapsed_display_driver

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 50000: clk cycles per digit scan slot; legal range 2..2^20.
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port elapsed  input  16  unsigned binary count from the stopwatch controller.
REQ-005 SHALL have port update  input  1  request to sample elapsed and convert it.
REQ-006 SHALL have port blank  input  1  forces all digits off while high.
REQ-007 SHALL have port busy  output  1  conversion in progress.
REQ-008 SHALL have port done  output  1  one-cycle pulse, new bcd value valid.
REQ-009 SHALL have port bcd  output  20  five packed BCD digits, [3:0] = units, [19:16] = ten-thousands.
REQ-010 SHALL have port digit_sel  output  5  one-hot active-low digit enable, bit i drives BCD digit i.
REQ-011 SHALL have port seg  output  7  active-low segments, seg[0]=a ... seg[6]=g.

Function
REQ-012 Converter FSM SHALL have states IDLE, CONV, DONE.
REQ-013 IDLE: on a clk edge with update=1, SHALL capture elapsed into a 16-bit shift register, clear a 20-bit BCD accumulator and an iteration counter, go to CONV.
REQ-014 CONV: each cycle SHALL add 3 to every accumulator digit >= 5, then shift {accumulator, shift register} left by one (double dabble); after the 16th iteration go to DONE.
REQ-015 DONE: SHALL load bcd from the accumulator and assert done for exactly that one cycle, then return to IDLE.
REQ-016 Latency: update accepted at edge E0 -> bcd updated and done high following edge E17; busy high from after E0 until after E16.
REQ-017 bcd SHALL hold its value between conversions; it is never partially updated.
REQ-018 update=1 during CONV or DONE SHALL set a single pending flag (further requests merge); on return to IDLE with pending set, a new conversion SHALL start on the next edge, sampling elapsed at that edge, and the flag clears.
REQ-019 update held high continuously SHALL yield back-to-back conversions, one every 18 cycles.
REQ-020 Full range SHALL convert exactly: 0 -> 20'h00000, 65535 -> 20'h65535; no digit ever exceeds 9.
REQ-021 Scan counter SHALL count 0..SCAN_DIV-1 and wrap; on wrap, the digit index SHALL advance 0,1,2,3,4,0,...
REQ-022 digit_sel SHALL drive low only the bit of the current digit index; all high while blank=1.
REQ-023 seg SHALL show the bcd digit at the current index with standard 0-9 patterns (e.g. 0 = 7'b1000000, 1 = 7'b1111001).
REQ-024 Leading-zero blanking: a digit above the most significant non-zero digit SHALL output seg = 7'h7F; digit 0 SHALL always be shown.
REQ-025 digit_sel and seg SHALL be registered, changing together on the same edge, glitch-free.
REQ-026 Scan logic SHALL run independently of the converter; bcd changes appear at the next displayed slot.

Reset
REQ-027 rst=1 SHALL immediately force: FSM IDLE, pending 0, busy 0, done 0, bcd 20'h00000, scan counter 0, digit index 0.
REQ-028 During and after reset, digit_sel SHALL be 5'b11110 and seg 7'b1000000 (shows "0").
REQ-029 rst asserted mid-conversion SHALL abort it; bcd stays 0 and no done pulse occurs.
REQ-030 First update after rst release SHALL be accepted normally per REQ-013.

Verification
REQ-031 elapsed=12345, update pulse at E0 -> done high after E17, bcd=20'h12345, busy high 16 cycles.
REQ-032 elapsed=65535 then elapsed=0 conversions -> bcd=20'h65535, then 20'h00000; display shows only digit 0 = "0", digits 1-4 seg=7'h7F.
REQ-033 update at E0, second update at E5 with elapsed changed to 42 -> second conversion starts the edge after done, final bcd=20'h00042; third update during busy merges into one.
REQ-034 SCAN_DIV=4, bcd=20'h00305 -> digit_sel cycles 11110,11101,11011,10111,01111 every 4 clocks; segs show 5,0,3 then 7'h7F,7'h7F.
REQ-035 rst pulse at 8th CONV cycle -> busy 0 at once, no done, bcd=0; blank=1 -> digit_sel=5'b11111.

Source files
------------

// File: rtl/elapsed_display_driver.sv
// Binary-to-BCD converter (serial double dabble) with a multiplexed,
// leading-zero-blanked 5-digit 7-segment scan driver.
module elapsed_display_driver #(
  parameter int unsigned SCAN_DIV = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] elapsed,
  input  logic        update,
  input  logic        blank,
  output logic        busy,
  output logic        done,
  output logic [19:0] bcd,
  output logic [4:0]  digit_sel,
  output logic [6:0]  seg
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CONV = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam int unsigned CW = $clog2(SCAN_DIV);

  logic [1:0]    state_q, state_d;
  logic          pend_q, pend_d;
  logic [15:0]   sr_q, sr_d;
  logic [19:0]   acc_q, acc_d;
  logic [19:0]   adj;
  logic [3:0]    iter_q, iter_d;
  logic [19:0]   bcd_q, bcd_d;
  logic          done_q, done_d;

  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic          wrap;
  logic [3:0]    dig;
  logic          show;
  logic [4:0]    sel_q, sel_d;
  logic [6:0]    seg_q, seg_d;

  function automatic logic [6:0] seg_pat(input logic [3:0] d);
    case (d)
      4'd0:    seg_pat = 7'b1000000;
      4'd1:    seg_pat = 7'b1111001;
      4'd2:    seg_pat = 7'b0100100;
      4'd3:    seg_pat = 7'b0110000;
      4'd4:    seg_pat = 7'b0011001;
      4'd5:    seg_pat = 7'b0010010;
      4'd6:    seg_pat = 7'b0000010;
      4'd7:    seg_pat = 7'b1111000;
      4'd8:    seg_pat = 7'b0000000;
      4'd9:    seg_pat = 7'b0010000;
      default: seg_pat = 7'h7F;
    endcase
  endfunction

  always_comb begin
    adj = acc_q;
    for (int unsigned i = 0; i < 5; i++) begin
      if (acc_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
    end
  end

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    sr_d    = sr_q;
    acc_d   = acc_q;
    iter_d  = iter_q;
    bcd_d   = bcd_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (update || pend_q) begin
          sr_d    = elapsed;
          acc_d   = '0;
          iter_d  = '0;
          pend_d  = 1'b0;
          state_d = S_CONV;
        end
      end
      S_CONV: begin
        pend_d        = pend_q | update;
        {acc_d, sr_d} = {adj[18:0], sr_q, 1'b0};
        iter_d        = iter_q + 4'd1;
        if (iter_q == 4'd15) state_d = S_DONE;
      end
      S_DONE: begin
        pend_d  = pend_q | update;
        bcd_d   = acc_q;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      pend_q  <= 1'b0;
      sr_q    <= '0;
      acc_q   <= '0;
      iter_q  <= '0;
      bcd_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      sr_q    <= sr_d;
      acc_q   <= acc_d;
      iter_q  <= iter_d;
      bcd_q   <= bcd_d;
      done_q  <= done_d;
    end
  end

  assign busy = (state_q == S_CONV);
  assign done = done_q;
  assign bcd  = bcd_q;

  assign wrap  = (cnt_q == CW'(SCAN_DIV - 1));
  assign cnt_d = wrap ? '0 : cnt_q + CW'(1);
  assign idx_d = wrap ? ((idx_q == 3'd4) ? 3'd0 : idx_q + 3'd1) : idx_q;

  // Outputs are decoded from the next index so select and segments move on the same edge.
  always_comb begin
    dig  = bcd_q[3:0];
    show = 1'b1;
    case (idx_d)
      3'd1: begin dig = bcd_q[7:4];   show = |bcd_q[19:4];  end
      3'd2: begin dig = bcd_q[11:8];  show = |bcd_q[19:8];  end
      3'd3: begin dig = bcd_q[15:12]; show = |bcd_q[19:12]; end
      3'd4: begin dig = bcd_q[19:16]; show = |bcd_q[19:16]; end
      default: ;
    endcase
    sel_d = blank ? '1 : ~(5'b00001 << idx_d);
    seg_d = show ? seg_pat(dig) : 7'h7F;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      idx_q <= '0;
      sel_q <= 5'b11110;
      seg_q <= 7'b1000000;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      sel_q <= sel_d;
      seg_q <= seg_d;
    end
  end

  assign digit_sel = sel_q;
  assign seg       = seg_q;

endmodule

// File: tb/tb_elapsed_display_driver.sv
// Randomised + directed bench for elapsed_display_driver against a
// decimal-arithmetic reference model evaluated every clock.
module tb_elapsed_display_driver;
  localparam int DIV = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] elapsed = '0;
  logic        update = 1'b0;
  logic        blank = 1'b0;
  logic        busy, done;
  logic [19:0] bcd;
  logic [4:0]  digit_sel;
  logic [6:0]  seg;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  elapsed_display_driver #(.SCAN_DIV(DIV)) dut (
    .clk(clk), .rst(rst), .elapsed(elapsed), .update(update), .blank(blank),
    .busy(busy), .done(done), .bcd(bcd), .digit_sel(digit_sel), .seg(seg)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int pow10(input int i);
    int p = 1;
    for (int k = 0; k < i; k++) p = p * 10;
    return p;
  endfunction

  function automatic logic [19:0] to_bcd(input int v);
    logic [19:0] r = '0;
    for (int i = 0; i < 5; i++) r[4*i +: 4] = 4'((v / pow10(i)) % 10);
    return r;
  endfunction

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'h40; 1: return 7'h79; 2: return 7'h24; 3: return 7'h30;
      4: return 7'h19; 5: return 7'h12; 6: return 7'h02; 7: return 7'h78;
      8: return 7'h00; 9: return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  function automatic logic [6:0] disp(input int val, input int i);
    if (i != 0 && val < pow10(i)) return 7'h7F;
    return seg_of((val / pow10(i)) % 10);
  endfunction

  // Reference model: conversion tracked as "cycles since accept", value kept as an integer.
  bit         m_active, m_pend, m_busy, m_done;
  int         m_k, m_cap, m_val, m_cnt, m_idx;
  logic [4:0] m_sel;
  logic [6:0] m_seg;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_active = 0; m_pend = 0; m_busy = 0; m_done = 0;
      m_k = 0; m_cap = 0; m_val = 0; m_cnt = 0; m_idx = 0;
      m_sel = 5'b11110; m_seg = 7'h40;
    end else begin
      if (m_cnt == DIV - 1) begin
        m_cnt = 0;
        m_idx = (m_idx + 1) % 5;
      end else m_cnt++;
      m_sel = 5'h1F;
      if (!blank) m_sel[m_idx] = 1'b0;
      m_seg  = disp(m_val, m_idx);
      m_done = 0;
      if (!m_active) begin
        if (update || m_pend) begin
          m_active = 1; m_k = 0; m_cap = int'(elapsed); m_pend = 0;
        end
      end else begin
        if (update) m_pend = 1;
        m_k++;
        if (m_k == 17) begin
          m_val = m_cap; m_done = 1; m_active = 0;
        end
      end
      m_busy = m_active && (m_k < 16);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", 32'(busy), 32'(m_busy));
      chk("done", 32'(done), 32'(m_done));
      chk("bcd", 32'(bcd), 32'(to_bcd(m_val)));
      chk("digit_sel", 32'(digit_sel), 32'(m_sel));
      chk("seg", 32'(seg), 32'(m_seg));
    end
  end

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_done(output int n);
    n = 99;
    for (int c = 1; c <= 60; c++) begin
      cyc();
      if (done) begin
        n = c;
        break;
      end
    end
  endtask

  task automatic run_conv(input logic [15:0] v, output int lat, output int bc);
    elapsed = v;
    update  = 1'b1;
    cyc();
    update = 1'b0;
    bc  = busy ? 1 : 0;
    lat = 99;
    for (int c = 1; c <= 40; c++) begin
      cyc();
      if (busy) bc++;
      if (done) begin
        lat = c;
        break;
      end
    end
  endtask

  initial begin
    int lat, bc, n, cnt;
    logic [4:0] prev;
    logic [4:0] exp_sel [5];
    logic [6:0] exp_seg [5];
    exp_sel = '{5'b11110, 5'b11101, 5'b11011, 5'b10111, 5'b01111};
    exp_seg = '{7'h12, 7'h40, 7'h30, 7'h7F, 7'h7F};

    #1 rst = 1'b1;
    chk_en = 1'b1;
    repeat (3) cyc();
    chk("rst_sel", 32'(digit_sel), 32'h1E);
    chk("rst_seg", 32'(seg), 32'h40);
    chk("rst_bcd", 32'(bcd), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    rst = 1'b0;
    repeat (3) cyc();

    run_conv(16'd12345, lat, bc);
    chk("lat_12345", 32'(lat), 32'd17);
    chk("busy_cycles", 32'(bc), 32'd16);
    chk("bcd_12345", 32'(bcd), 32'h12345);

    run_conv(16'd65535, lat, bc);
    chk("bcd_65535", 32'(bcd), 32'h65535);
    run_conv(16'd0, lat, bc);
    chk("bcd_0", 32'(bcd), 32'h0);
    repeat (2) cyc();
    for (int c = 0; c < 5 * DIV; c++) begin
      chk("zero_seg", 32'(seg), (digit_sel == 5'b11110) ? 32'h40 : 32'h7F);
      cyc();
    end

    // Merge: second request during busy, third request also merges.
    elapsed = 16'd7;
    update  = 1'b1;
    cyc();
    update = 1'b0;
    repeat (4) cyc();
    elapsed = 16'd42;
    update  = 1'b1;
    cyc();
    update = 1'b0;
    repeat (3) cyc();
    update = 1'b1;
    cyc();
    update = 1'b0;
    wait_done(n);
    chk("bcd_first", 32'(bcd), 32'h7);
    wait_done(n);
    chk("merge_gap", 32'(n), 32'd18);
    chk("bcd_42", 32'(bcd), 32'h42);
    cnt = 0;
    for (int c = 0; c < 40; c++) begin
      cyc();
      if (done) cnt++;
    end
    chk("merge_extra", 32'(cnt), 32'd0);

    run_conv(16'd305, lat, bc);
    chk("bcd_305", 32'(bcd), 32'h305);
    prev = digit_sel;
    n = 0;
    for (int c = 0; c < 60; c++) begin
      cyc();
      if (prev == 5'b01111 && digit_sel == 5'b11110) begin
        n = 1;
        break;
      end
      prev = digit_sel;
    end
    chk("scan_align", 32'(n), 32'd1);
    for (int s = 0; s < 5; s++) begin
      for (int c = 0; c < DIV; c++) begin
        if (s != 0 || c != 0) cyc();
        chk("scan_sel", 32'(digit_sel), 32'(exp_sel[s]));
        chk("scan_seg", 32'(seg), 32'(exp_seg[s]));
      end
    end

    // Abort mid-conversion.
    elapsed = 16'd999;
    update  = 1'b1;
    cyc();
    update = 1'b0;
    repeat (7) cyc();
    rst = 1'b1;
    #1;
    chk("abort_busy", 32'(busy), 32'h0);
    chk("abort_bcd", 32'(bcd), 32'h0);
    cyc();
    rst = 1'b0;
    cnt = 0;
    for (int c = 0; c < 30; c++) begin
      cyc();
      if (done) cnt++;
    end
    chk("abort_done", 32'(cnt), 32'd0);
    chk("abort_bcd_hold", 32'(bcd), 32'h0);
    blank = 1'b1;
    cyc();
    chk("blank_sel", 32'(digit_sel), 32'h1F);
    blank = 1'b0;
    run_conv(16'd4321, lat, bc);
    chk("bcd_4321", 32'(bcd), 32'h4321);
    chk("lat_4321", 32'(lat), 32'd17);

    update  = 1'b1;
    elapsed = 16'd60000;
    repeat (60) cyc();
    for (int c = 0; c < 1500; c++) begin
      update  = ($urandom_range(0, 9) == 0);
      blank   = ($urandom_range(0, 15) == 0);
      rst     = ($urandom_range(0, 399) == 0);
      case ($urandom_range(0, 7))
        0:       elapsed = 16'hFFFF;
        1:       elapsed = 16'h0000;
        default: elapsed = 16'($urandom);
      endcase
      cyc();
    end
    rst = 1'b0;
    update = 1'b0;
    blank = 1'b0;
    repeat (40) cyc();

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
